// File: rtl/fp_mul_sched.sv
// fp_mul_sched: round-robin two-port scheduler sharing a 2-stage 24-bit FP multiply pipeline with per-port held results
module fp_mul_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_a,
  input  logic [23:0] req0_b,
  output logic        res0_valid,
  output logic [23:0] res0_data,
  input  logic        res0_ack,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_a,
  input  logic [23:0] req1_b,
  output logic        res1_valid,
  output logic [23:0] res1_data,
  input  logic        res1_ack
);
  logic [1:0] busy, res_v, elig, grant, ack;
  logic [1:0][23:0] res_d;
  logic rr, s1_v, s1_p, s1_z, s1_s, s2_v, s2_p, s2_z, s2_s;
  logic [6:0] s1_e, s2_e;
  logic [17:0] s1_m;
  logic [15:0] s2_f;
  logic [23:0] a, b;
  assign elig = {req1_valid & ~busy[1], req0_valid & ~busy[0]};
  assign grant[0] = elig[0] & (~elig[1] | ~rr);
  assign grant[1] = elig[1] & (~elig[0] | rr);
  assign ack = {res1_ack, res0_ack};
  assign a = grant[1] ? req1_a : req0_a;
  assign b = grant[1] ? req1_b : req0_b;
  assign {req1_ready, req0_ready} = grant;
  assign {res1_valid, res0_valid} = res_v;
  assign res0_data = res_d[0];
  assign res1_data = res_d[1];
  always_ff @(posedge clk)
    if (rst) begin
      busy <= '0;
      res_v <= '0;
      res_d <= '0;
      rr <= 1'b0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_p <= 1'b0;
      s1_z <= 1'b0;
      s1_s <= 1'b0;
      s1_e <= '0;
      s1_m <= '0;
      s2_p <= 1'b0;
      s2_z <= 1'b0;
      s2_s <= 1'b0;
      s2_e <= '0;
      s2_f <= '0;
    end else begin
      if (|grant) rr <= ~grant[1];
      s1_v <= |grant;
      s1_p <= grant[1];
      s1_z <= (a[22:0] == 23'd0) | (b[22:0] == 23'd0);
      s1_s <= a[23] ^ b[23];
      s1_e <= a[22:16] + b[22:16] - 7'd63;
      s1_m <= 18'((34'({1'b1, a[15:0]}) * 34'({1'b1, b[15:0]})) >> 16);
      s2_v <= s1_v;
      s2_p <= s1_p;
      s2_z <= s1_z;
      s2_s <= s1_s;
      s2_e <= s1_e + {6'd0, s1_m[17]};
      s2_f <= s1_m[17] ? s1_m[16:1] : s1_m[15:0];
      for (int i = 0; i < 2; i++) begin
        busy[i] <= grant[i] | (busy[i] & ~(ack[i] & res_v[i]));
        if (s2_v && s2_p == 1'(i)) begin
          res_v[i] <= 1'b1;
          res_d[i] <= s2_z ? {s2_s, 23'd0} : {s2_s, s2_e, s2_f};
        end else if (ack[i]) res_v[i] <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fp_mul_sched.sv
// tb_fp_mul_sched: directed table-driven and sequence checks for fp_mul_sched
module tb_fp_mul_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, res0_ack = 1'b0, res1_ack = 1'b0;
  logic [23:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, res0_valid, res1_valid;
  logic [23:0] res0_data, res1_data;
  int tests = 0, fails = 0;
  typedef struct {
    int p;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] r;
  } vec_t;
  vec_t vt[10];
  always #5 clk = ~clk;
  fp_mul_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .res0_valid(res0_valid), .res0_data(res0_data), .res0_ack(res0_ack),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res1_valid(res1_valid), .res1_data(res1_data), .res1_ack(res1_ack)
  );
  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  function automatic logic rdy(int p);
    return p == 1 ? req1_ready : req0_ready;
  endfunction
  function automatic logic rv(int p);
    return p == 1 ? res1_valid : res0_valid;
  endfunction
  function automatic logic [23:0] rd(int p);
    return p == 1 ? res1_data : res0_data;
  endfunction
  task automatic drive(int p, logic v, logic [23:0] a, logic [23:0] b);
    if (p == 1) begin
      req1_valid = v;
      req1_a = a;
      req1_b = b;
    end else begin
      req0_valid = v;
      req0_a = a;
      req0_b = b;
    end
  endtask
  task automatic set_ack(int p, logic v);
    if (p == 1) res1_ack = v;
    else res0_ack = v;
  endtask
  task automatic run_op(int p, logic [23:0] a, logic [23:0] b, logic [23:0] r, string n);
    int w = 0;
    int k = 1;
    drive(p, 1'b1, a, b);
    #1;
    while (!rdy(p) && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check({n, " ready"}, 32'(rdy(p)), 1);
    @(negedge clk);
    drive(p, 1'b0, a, b);
    #1;
    while (!rv(p) && k < 12) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({n, " latency"}, k, 3);
    check({n, " data"}, 32'(rd(p)), 32'(r));
    check({n, " other idle"}, 32'(rv(1 - p)), 0);
    set_ack(p, 1'b1);
    @(negedge clk);
    set_ack(p, 1'b0);
    #1;
    check({n, " cleared"}, 32'(rv(p)), 0);
  endtask
  initial begin
    int acc[8];
    int na, bad, w;
    logic [23:0] held;
    vt[0] = '{0, 24'h3F8000, 24'h400000, 24'h408000};
    vt[1] = '{1, 24'h3F8000, 24'h3F8000, 24'h402000};
    vt[2] = '{0, 24'h000000, 24'hC08000, 24'h800000};
    vt[3] = '{1, 24'hBF8000, 24'hC00000, 24'h408000};
    vt[4] = '{0, 24'h7F0000, 24'h7F0000, 24'h3F0000};
    vt[5] = '{1, 24'h010000, 24'h010000, 24'h430000};
    vt[6] = '{0, 24'h3FC000, 24'h3FC000, 24'h408800};
    vt[7] = '{1, 24'h000001, 24'h3F0000, 24'h000001};
    vt[8] = '{0, 24'h800000, 24'h3F8000, 24'h800000};
    vt[9] = '{1, 24'h3F0000, 24'hBF0000, 24'hBF0000};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset ready", {req1_ready, req0_ready}, 0);
    check("reset valid", {res1_valid, res0_valid}, 0);
    check("reset data0", 32'(res0_data), 0);
    check("reset data1", 32'(res1_data), 0);
    // both ports valid from reset: rr=0 favours port 0
    @(negedge clk);
    drive(0, 1'b1, 24'h3F0000, 24'h3F0000);
    drive(1, 1'b1, 24'hBF0000, 24'h3F0000);
    #1;
    check("both first grant", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    drive(0, 1'b0, 24'h0, 24'h0);
    #1;
    check("both second grant", {req1_ready, req0_ready}, 2'b10);
    @(negedge clk);
    drive(1, 1'b0, 24'h0, 24'h0);
    @(negedge clk);
    #1;
    check("both res0 first", {res1_valid, res0_valid}, 2'b01);
    check("both data0", 32'(res0_data), 32'h3F0000);
    @(negedge clk);
    #1;
    check("both res1 second", {res1_valid, res0_valid}, 2'b11);
    check("both data1", 32'(res1_data), 32'hBF0000);
    res0_ack = 1'b1;
    res1_ack = 1'b1;
    @(negedge clk);
    res0_ack = 1'b0;
    res1_ack = 1'b0;
    #1;
    check("both acked", {res1_valid, res0_valid}, 0);
    // hold port 0 result while port 1 runs back-to-back with earliest acks
    drive(0, 1'b1, 24'h3F8000, 24'h400000);
    w = 0;
    #1;
    while (!res0_valid && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("hold result ready", 32'(res0_valid), 1);
    held = res0_data;
    check("hold data", 32'(held), 32'h408000);
    drive(0, 1'b1, 24'h3F0000, 24'h3F0000);
    drive(1, 1'b1, 24'h3F8000, 24'h3F8000);
    na = 0;
    bad = 0;
    for (int c = 0; c < 17; c++) begin
      #1;
      if (req0_ready || !res0_valid || res0_data !== held) bad++;
      if (req1_ready && na < 8) begin
        acc[na] = c;
        na++;
      end
      if (res1_valid) begin
        check("b2b data1", 32'(res1_data), 32'h402000);
        check("ack and valid same cycle", 32'(req1_ready), 0);
      end
      res1_ack = res1_valid;
      @(negedge clk);
    end
    res1_ack = 1'b0;
    drive(1, 1'b0, 24'h0, 24'h0);
    drive(0, 1'b0, 24'h0, 24'h0);
    check("hold stable no ready", bad, 0);
    check("b2b accept count", na, 5);
    bad = 0;
    for (int i = 1; i < na; i++) if (acc[i] - acc[i-1] != 4) bad++;
    check("b2b spacing 4", bad, 0);
    w = 0;
    #1;
    while (!res1_valid && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("drain port1", 32'(res1_valid), 1);
    res1_ack = 1'b1;
    res0_ack = 1'b1;
    @(negedge clk);
    res1_ack = 1'b0;
    res0_ack = 1'b0;
    #1;
    check("drain cleared", {res1_valid, res0_valid}, 0);
    // reset with a held result on port 1 and an op in flight on port 0
    drive(1, 1'b1, 24'h3F0000, 24'h3F0000);
    @(negedge clk);
    drive(1, 1'b0, 24'h0, 24'h0);
    repeat (3) @(negedge clk);
    #1;
    check("pre-reset held1", 32'(res1_valid), 1);
    drive(0, 1'b1, 24'h3F8000, 24'h400000);
    #1;
    check("pre-reset accept0", 32'(req0_ready), 1);
    @(negedge clk);
    drive(0, 1'b0, 24'h0, 24'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (res0_valid || res1_valid || res0_data !== 24'h0 || res1_data !== 24'h0 || req0_ready || req1_ready) bad++;
      @(negedge clk);
    end
    check("reset mid-op quiet", bad, 0);
    for (int i = 0; i < 10; i++) run_op(vt[i].p, vt[i].a, vt[i].b, vt[i].r, $sformatf("vec%0d", i));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_mul_sched.md
# fp_mul_sched

Two-port scheduler that shares one 24-bit floating-point multiply pipeline (exponent adder, mantissa multiplier and sign stage in stage 1, normaliser in stage 2) between two requesters. It arbitrates round-robin, issues at most one operation per cycle and tracks each in-flight operation's owner. It forces zero results and holds each result in a per-port register until the owner acknowledges it. It sits between the accelerator's operand sources and the multiply datapath.

## Interface
- No parameters. Word format fixed: [23] sign, [22:16] exponent (bias 63), [15:0] fraction (hidden 1 not stored).
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 has operands.
- req0_ready  out  1  port 0 operands accepted this cycle.
- req0_a, req0_b  in  24  port 0 operands.
- res0_valid  out  1  port 0 result held.
- res0_data  out  24  port 0 result.
- res0_ack  in  1  port 0 consumes result.
- req1_*, res1_*  same set for port 1.

## Operation
- Per-port busy flag. Set on accept (req_valid && req_ready). Cleared at the edge where res_ack && res_valid.
- Each port has at most one outstanding operation, counting in-flight work and unread results.
- Eligible(i) = req_valid_i && !busy_i.
- Round-robin pointer rr, 1 bit:
  - Both ports eligible: grant port rr.
  - Only one eligible: grant that port.
  - After any grant, rr <= ~granted port.
  - No grant: rr unchanged.
- req_ready_i = grant_i. It is combinational from req_valid_0/1, busy and rr. Requesters must not make valid depend on ready.
- Granted operands are muxed straight into the stage-1 inputs in the accept cycle.
- Tag pipeline, two stages, travels alongside the datapath: {valid, port, zero, sign}.
  - zero = either operand has exponent == 0 and fraction == 0.
  - sign = a[23] ^ b[23].
- Stage-2 output with valid tag is written into res_data of the tagged port, and that port's res_valid is set.
  - zero tag set: res_data = {sign, 23'b0}.
  - Otherwise: res_data = {sign, normalised exp, normalised fraction}.
- Exponent arithmetic is exp_a + exp_b − 63 (+1 on normalise) modulo 128. Overflow and underflow are not detected; the result wraps.
- res_data and res_valid stay stable until acked. An ack while res_valid = 0 is ignored.

## Timing
- Accept at edge E0 → stage 1 captures at E0 → normaliser captures at E1 → result register captures at E2.
- res_valid is high from the cycle after E2.
- Latency: 3 edges from accept to result register.
- Earliest ack edge is E3, which clears busy. The port becomes eligible in the following cycle, so earliest re-accept is E4.
- Single-port throughput: 1 op per 4 cycles. Both ports interleaved: 2 ops per 4 cycles. Pipeline never holds more than 2 valid tags.
- No write collisions: a port's result slot is empty whenever its tag is in flight.
- Reset values: req0/1_ready = 0 (busy clear; ready follows valid from the first cycle after reset), res0/1_valid = 0, res0/1_data = 24'h000000, rr = 0, busy = 0, tag valids = 0.
- Reset mid-operation: in-flight tags are dropped, no res_valid is produced, and held results are discarded.
- Simultaneous ack and new req_valid on the same port, same cycle: the request is not accepted that cycle, because busy is still set.

## Test plan
- Port 0 only, a = 0x3F8000 (1.5), b = 0x400000 (2.0) → req0_ready in the valid cycle; res0_valid 3 edges later with res0_data = 0x408000 (3.0); res1_valid stays 0.
- Both ports valid from reset: port 0 a = 0x3F0000, b = 0x3F0000; port 1 a = 0xBF0000, b = 0x3F0000 → port 0 accepted first, port 1 one cycle later; results 0x3F0000 and 0xBF0000 one cycle apart.
- Zero operand: a = 0x000000, b = 0xC08000 → res_data = 0x800000.
- Hold result: never assert res0_ack for 10 cycles with req0_valid high → res0_data stable; req0_ready stays 0; port 1 is still served every 4 cycles.
- Ack at the earliest edge, back-to-back on one port → accepts spaced exactly 4 cycles apart.
- Assert rst one cycle after accept → no res_valid afterwards; all outputs at reset values; the next request is accepted normally.
